// File: rtl/core_exclusive_monitor_pkg.sv
// Shared types for the exclusive-access monitor: data/address words,
// the request FSM states and the default reservation granule size.
package core_exclusive_monitor_pkg;

    localparam int unsigned GranuleLogDefault = 2;

    typedef logic [31:0] word_t;
    typedef logic [29:0] ptr_t;
    typedef logic [3:0]  reg_num_t;

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StFail
    } mon_state_t;

endpackage

// File: rtl/core_exclusive_monitor.sv
// LDREX/STREX reservation monitor sitting between the load/store unit and the bus.
// Forwards requests, tracks one granule reservation and fails STREX locally when it is lost.
module core_exclusive_monitor
    import core_exclusive_monitor_pkg::*;
#(
    parameter int unsigned GRANULE_LOG = GranuleLogDefault
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_start,
    input  ptr_t        in_addr,
    input  logic        in_write,
    input  logic        in_exclusive,
    input  word_t       in_data_wr,
    input  logic [3:0]  in_data_be,
    output logic        in_ready,
    output word_t       in_data_rd,
    output logic        strex_fail,
    output logic        bus_start,
    output ptr_t        bus_addr,
    output logic        bus_write,
    output word_t       bus_data_wr,
    output logic [3:0]  bus_data_be,
    input  logic        bus_ready,
    input  word_t       bus_data_rd,
    input  logic        snoop_valid,
    input  ptr_t        snoop_addr,
    input  logic        clrex
);

    localparam int unsigned TagW = 30 - GRANULE_LOG;
    typedef logic [TagW-1:0] tag_t;

    mon_state_t state;
    logic       res_valid;
    tag_t       res_tag;
    logic       op_excl;

    logic       res_valid_next;
    tag_t       res_tag_next;

    tag_t in_tag, snoop_tag, bus_tag;
    assign in_tag    = in_addr[29:GRANULE_LOG];
    assign snoop_tag = snoop_addr[29:GRANULE_LOG];
    assign bus_tag   = bus_addr[29:GRANULE_LOG];

    logic unused_snoop_low;
    assign unused_snoop_low = ^snoop_addr[GRANULE_LOG-1:0];

    // A STREX only sees the reservation after this cycle's snoop/clrex have been applied.
    logic res_live, strex_ok, strex_req;
    assign res_live  = res_valid && !clrex && !(snoop_valid && snoop_tag == res_tag);
    assign strex_ok  = res_live && (in_tag == res_tag);
    assign strex_req = (state == StIdle) && in_start && in_write && in_exclusive;

    always_comb begin
        res_valid_next = res_valid;
        res_tag_next   = res_tag;
        if (strex_req && !strex_ok) begin
            res_valid_next = 1'b0;
        end
        if (state == StBus && bus_ready && op_excl) begin
            if (bus_write) begin
                res_valid_next = 1'b0;
            end else begin
                res_valid_next = 1'b1;
                res_tag_next   = bus_tag;
            end
        end
        // Clears are applied last so they win over a completing LDREX.
        if (clrex || (snoop_valid && snoop_tag == res_tag_next)) begin
            res_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= StIdle;
            res_valid   <= 1'b0;
            res_tag     <= '0;
            op_excl     <= 1'b0;
            in_ready    <= 1'b0;
            strex_fail  <= 1'b0;
            in_data_rd  <= '0;
            bus_start   <= 1'b0;
            bus_addr    <= '0;
            bus_write   <= 1'b0;
            bus_data_wr <= '0;
            bus_data_be <= '0;
        end else begin
            bus_start  <= 1'b0;
            in_ready   <= 1'b0;
            strex_fail <= 1'b0;
            res_valid  <= res_valid_next;
            res_tag    <= res_tag_next;
            unique case (state)
                StIdle: begin
                    if (in_start) begin
                        if (strex_req && !strex_ok) begin
                            state      <= StFail;
                            in_ready   <= 1'b1;
                            strex_fail <= 1'b1;
                        end else begin
                            state       <= StBus;
                            bus_start   <= 1'b1;
                            bus_addr    <= in_addr;
                            bus_write   <= in_write;
                            bus_data_wr <= in_data_wr;
                            bus_data_be <= in_data_be;
                            op_excl     <= in_exclusive;
                        end
                    end
                end
                StBus: begin
                    if (bus_ready) begin
                        state      <= StIdle;
                        in_ready   <= 1'b1;
                        in_data_rd <= bus_data_rd;
                    end
                end
                StFail: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    start_only_in_idle: assert property (
        @(posedge clk) disable iff (!rst_n) in_start |-> state == StIdle
    );

endmodule
